// File: rtl/lcd_mmio_controller_if.sv
// CPU-side MMIO bus for the LCD controller: a write strobe with offset and byte data,
// plus the combinational STATUS readback.
interface lcd_mmio_controller_if;
  logic        wr_en;
  logic [1:0]  addr;
  logic [7:0]  wdata;
  logic [31:0] rdata;

  modport master (output wr_en, addr, wdata, input  rdata);
  modport slave  (input  wr_en, addr, wdata, output rdata);
endinterface

// File: rtl/lcd_mmio_controller.sv
// HD44780-style LCD driver: CPU byte writes are queued and replayed as
// setup / enable-pulse / hold / settle sequences on the LCD pins.
module lcd_mmio_controller #(
  parameter int FIFO_DEPTH        = 8,
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 4,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 40,
  parameter int CLEAR_WAIT_CYCLES = 160
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lcd_mmio_controller_if.slave  bus,
  output logic [7:0]            lcd_data,
  output logic [1:0]            lcd_ctrl,
  output logic                  lcd_enable,
  output logic                  busy
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYCLES, PULSE_CYCLES),
                                         max_of(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                  CLEAR_WAIT_CYCLES);
  localparam int CNT_W  = $clog2(MAX_CYC) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } entry_t;

  entry_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]   count;
  logic                overflow;
  logic                full, empty;
  logic                push_req, push_ok, pop, clr_ovf;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                enable_n;
  logic                rs;
  logic                is_clear;

  assign full     = (count == FCNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus.wr_en && (bus.addr == ADDR_DATA || bus.addr == ADDR_CMD);
  // A full queue can still take a byte on the edge the FSM pops one out.
  assign push_ok  = push_req && (!full || pop);
  assign clr_ovf  = bus.wr_en && (bus.addr == ADDR_CTRL) && bus.wdata[0];
  assign busy     = (state != S_IDLE) || !empty;
  assign lcd_ctrl = {rs, 1'b0};
  assign is_clear = !rs && (lcd_data == 8'h01 || lcd_data == 8'h02);

  // NOTE: queue storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= entry_t'{rs: (bus.addr == ADDR_DATA), data: bus.wdata};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    enable_n = lcd_enable;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_n   = CNT_W'(SETUP_CYCLES - 1);
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          enable_n = 1'b1;
          cnt_n    = CNT_W'(PULSE_CYCLES - 1);
          state_n  = S_PULSE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          enable_n = 1'b0;
          cnt_n    = CNT_W'(HOLD_CYCLES - 1);
          state_n  = S_HOLD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          cnt_n   = is_clear ? CNT_W'(CLEAR_WAIT_CYCLES - 1) : CNT_W'(CMD_WAIT_CYCLES - 1);
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  // lcd_data/rs only move on the pop edge and are held through WAIT and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lcd_enable <= 1'b0;
      lcd_data   <= 8'h00;
      rs         <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lcd_enable <= enable_n;
      if (pop) begin
        lcd_data <= mem[rd_ptr].data;
        rs       <= mem[rd_ptr].rs;
      end
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.addr == ADDR_STATUS) begin
      bus.rdata[0]    = full;
      bus.rdata[1]    = empty;
      bus.rdata[2]    = busy;
      bus.rdata[3]    = overflow;
      bus.rdata[15:8] = 8'(count);
    end
  end

endmodule

// File: tb/tb_lcd_mmio_controller.sv
// Directed bench for lcd_mmio_controller: pin timing, command settle times,
// overflow, STATUS readback, full-with-pop acceptance and mid-sequence reset.
module tb_lcd_mmio_controller;
  localparam int DEPTH = 8, SETUP = 2, PULSE = 4, HOLD = 2, CMD_WAIT = 40, CLR_WAIT = 160;
  localparam int BYTE_PERIOD = SETUP + PULSE + HOLD + CMD_WAIT + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;
  logic       busy;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         wr_edge = 0;

  lcd_mmio_controller_if bus ();

  lcd_mmio_controller #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE),
    .HOLD_CYCLES(HOLD), .CMD_WAIT_CYCLES(CMD_WAIT), .CLEAR_WAIT_CYCLES(CLR_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .lcd_data(lcd_data),
    .lcd_ctrl(lcd_ctrl), .lcd_enable(lcd_enable), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the strobe across exactly one rising edge; wr_edge records which one.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    step();
    wr_edge   = cyc;
    bus.wr_en = 1'b0;
    bus.addr  = 2'd0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rdata;
    bus.addr = 2'd0;
  endtask

  task automatic wait_idle(input int limit, output int took);
    took = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (!busy) begin
        took = k;
        break;
      end
    end
  endtask

  // Writes one byte into an idle controller and times its complete pin sequence.
  task automatic run_byte(input logic [1:0] a, input logic [7:0] d, input logic [1:0] ctrl,
                          input int settle, input string name);
    int rise_k = -1, fall_k = -1, done_k = -1, hi_cnt = 0;
    logic prev_en = 1'b0;
    bus_write(a, d);
    checks++;
    if ({busy, lcd_enable} !== 2'b10) begin
      errors++;
      $display("FAIL %s_after_write: busy/en=%b expected 10", name, {busy, lcd_enable});
    end
    for (int k = 1; k <= 400; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if ({lcd_data, lcd_ctrl} !== {d, ctrl}) begin
          errors++;
          $display("FAIL %s_load: data/ctrl=%h/%b expected %h/%b", name, lcd_data, lcd_ctrl, d, ctrl);
        end
      end
      if (lcd_enable) hi_cnt++;
      if (lcd_enable && !prev_en && rise_k < 0) rise_k = k;
      if (!lcd_enable && prev_en && fall_k < 0) fall_k = k;
      prev_en = lcd_enable;
      if (!busy) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (rise_k !== 1 + SETUP) begin
      errors++;
      $display("FAIL %s_rise: enable rose at +%0d expected +%0d", name, rise_k, 1 + SETUP);
    end
    checks++;
    if (fall_k - rise_k !== PULSE || hi_cnt !== PULSE) begin
      errors++;
      $display("FAIL %s_pulse: width=%0d high_cycles=%0d expected %0d", name, fall_k - rise_k, hi_cnt, PULSE);
    end
    checks++;
    if (done_k !== 1 + SETUP + PULSE + HOLD + settle) begin
      errors++;
      $display("FAIL %s_done: busy fell at +%0d expected +%0d", name, done_k, 1 + SETUP + PULSE + HOLD + settle);
    end
    checks++;
    if ({lcd_data, lcd_ctrl} !== {d, ctrl}) begin
      errors++;
      $display("FAIL %s_held: data/ctrl=%h/%b expected %h/%b", name, lcd_data, lcd_ctrl, d, ctrl);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    bus.wr_en = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 8'h00;
    rst_n     = 1'b0;
    #3;
    checks++;
    if ({lcd_data, lcd_ctrl, lcd_enable, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: data=%h ctrl=%b en=%b busy=%b expected all 0", lcd_data, lcd_ctrl, lcd_enable, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0000_0002) begin
      errors++;
      $display("FAIL reset_status: got %h expected 00000002", v);
    end
  endtask

  task automatic test_data_byte();
    run_byte(2'd0, 8'h41, 2'b10, CMD_WAIT, "data41");
  endtask

  task automatic test_commands();
    logic [31:0] v;
    run_byte(2'd1, 8'h01, 2'b00, CLR_WAIT, "clear01");
    run_byte(2'd1, 8'h38, 2'b00, CMD_WAIT, "cmd38");
    bus_write(2'd2, 8'h55);
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0000_0002 || busy !== 1'b0) begin
      errors++;
      $display("FAIL status_write_ignored: status=%h busy=%b expected 00000002/0", v, busy);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0]  got [$];
    int          rises [$];
    logic        prev_en, ctrl_ok;
    bus_write(2'd0, 8'h20);
    for (int i = 0; i < 9; i++) bus_write(2'd0, 8'h30 + 8'(i));
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0000_080D) begin
      errors++;
      $display("FAIL overflow_status: got %h expected 0000080d", v);
    end
    prev_en = lcd_enable;
    ctrl_ok = 1'b1;
    for (int k = 0; k < 1000 && busy; k++) begin
      step();
      if (lcd_enable && !prev_en) begin
        got.push_back(lcd_data);
        rises.push_back(cyc);
        if (lcd_ctrl !== 2'b10) ctrl_ok = 1'b0;
      end
      prev_en = lcd_enable;
    end
    checks++;
    if (got.size() !== 8 || busy !== 1'b0 || !ctrl_ok) begin
      errors++;
      $display("FAIL overflow_emit_count: bytes=%0d busy=%b ctrl_ok=%b expected 8/0/1", got.size(), busy, ctrl_ok);
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++;
      if (got[i] !== 8'h30 + 8'(i)) begin
        errors++;
        $display("FAIL overflow_order[%0d]: got %h expected %h", i, got[i], 8'h30 + 8'(i));
      end
      if (i > 0) begin
        checks++;
        if (rises[i] - rises[i-1] !== BYTE_PERIOD) begin
          errors++;
          $display("FAIL byte_spacing[%0d]: got %0d expected %0d", i, rises[i] - rises[i-1], BYTE_PERIOD);
        end
      end
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0000_000A) begin
      errors++;
      $display("FAIL overflow_sticky: got %h expected 0000000a", v);
    end
    bus_write(2'd3, 8'h01);
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0000_0002) begin
      errors++;
      $display("FAIL overflow_clear: got %h expected 00000002", v);
    end
  endtask

  task automatic test_status();
    logic [31:0] v0, v1, v3, v2;
    int took;
    for (int i = 0; i < 4; i++) bus_write(2'd0, 8'h41 + 8'(i));
    read_reg(2'd2, v2);
    read_reg(2'd0, v0);
    read_reg(2'd1, v1);
    read_reg(2'd3, v3);
    checks++;
    if (v2 !== 32'h0000_0304) begin
      errors++;
      $display("FAIL status_three_queued: got %h expected 00000304", v2);
    end
    checks++;
    if ({v0, v1, v3} !== 96'h0) begin
      errors++;
      $display("FAIL rdata_other_addr: got %h/%h/%h expected 0", v0, v1, v3);
    end
    wait_idle(1000, took);
    read_reg(2'd2, v2);
    checks++;
    if (took < 0 || v2 !== 32'h0000_0002 || lcd_data !== 8'h44) begin
      errors++;
      $display("FAIL status_drain: took=%0d status=%h last=%h expected idle/00000002/44", took, v2, lcd_data);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] v;
    int e0, took;
    bus_write(2'd0, 8'h50);
    e0 = wr_edge;
    for (int i = 1; i <= 8; i++) bus_write(2'd0, 8'h50 + 8'(i));
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0000_0805) begin
      errors++;
      $display("FAIL full_before_pop: got %h expected 00000805", v);
    end
    while (cyc < e0 + BYTE_PERIOD) step();
    bus_write(2'd0, 8'h59);
    read_reg(2'd2, v);
    checks++;
    if (wr_edge !== e0 + BYTE_PERIOD + 1 || v !== 32'h0000_0805) begin
      errors++;
      $display("FAIL full_with_pop: edge=+%0d status=%h expected +%0d/00000805", wr_edge - e0, v, BYTE_PERIOD + 1);
    end
    bus_write(2'd0, 8'h5A);
    read_reg(2'd2, v);
    checks++;
    if (v !== 32'h0000_080D) begin
      errors++;
      $display("FAIL full_no_pop: got %h expected 0000080d", v);
    end
    bus_write(2'd3, 8'h01);
    wait_idle(2000, took);
    read_reg(2'd2, v);
    checks++;
    if (took < 0 || v !== 32'h0000_0002 || lcd_data !== 8'h59) begin
      errors++;
      $display("FAIL full_pop_drain: took=%0d status=%h last=%h expected idle/00000002/59", took, v, lcd_data);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] v;
    int hi = 0;
    for (int i = 0; i < 5; i++) bus_write(2'd0, 8'h61 + 8'(i));
    step();
    #2;
    checks++;
    if (lcd_enable !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse_setup: enable=%b expected 1", lcd_enable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lcd_enable, busy, lcd_data, lcd_ctrl} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_pulse: en=%b busy=%b data=%h ctrl=%b expected all 0", lcd_enable, busy, lcd_data, lcd_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (lcd_enable) hi++;
    end
    read_reg(2'd2, v);
    checks++;
    if (hi !== 0 || v !== 32'h0000_0002) begin
      errors++;
      $display("FAIL after_reset_quiet: enable_cycles=%0d status=%h expected 0/00000002", hi, v);
    end
  endtask

  initial begin
    test_reset();
    test_data_byte();
    test_commands();
    test_overflow();
    test_status();
    test_full_pop();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
